// File: rtl/moving_sum_window_ctrl.sv
// Flush/prime/run sequencer in front of a complex moving-sum datapath; owns both summer handshakes.
// Optional statistics ports (drop_count, flush_count) are built when WIPHY_MSUM_CTRL_STATS_EN is defined.
module moving_sum_window_ctrl #(
  parameter int WIDTH        = 16,
  parameter int LENGTH       = 16,
  parameter int MAX_INFLIGHT = 4,
  localparam int SUM_WIDTH   = WIDTH + $clog2(LENGTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [2*WIDTH-1:0]     s_data,
  output logic                   sum_s_valid,
  input  logic                   sum_s_ready,
  output logic [2*WIDTH-1:0]     sum_s_data,
  input  logic                   sum_m_valid,
  output logic                   sum_m_ready,
  input  logic [2*SUM_WIDTH-1:0] sum_m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [2*SUM_WIDTH-1:0] m_data,
`ifdef WIPHY_MSUM_CTRL_STATS_EN
  output logic [31:0]            drop_count,
  output logic [15:0]            flush_count,
`endif
  output logic                   primed
);

  localparam int CNT_W = $clog2(LENGTH + 1);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0] PRIME_LAST = (LENGTH >= 2) ? CNT_W'(LENGTH - 2) : CNT_W'(0);
  localparam logic [INF_W-1:0] INF_MAX    = INF_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic             full_s;
  logic             in_hs_s;
  logic             out_hs_s;

  // Handshake steering decoded from the current state; everything quiet while reset is held.
  always_comb begin
    full_s      = (inflight_q == INF_MAX);
    s_ready     = 1'b0;
    sum_s_valid = 1'b0;
    sum_s_data  = '0;
    sum_m_ready = 1'b0;
    m_valid     = 1'b0;
    m_data      = sum_m_data;
    primed      = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_FLUSH: begin
          sum_s_valid = (cnt_q != FLUSH_LAST) && !full_s;
          sum_m_ready = 1'b1;
        end
        ST_PRIME: begin
          sum_s_valid = s_valid && !full_s;
          s_ready     = sum_s_ready && !full_s;
          sum_s_data  = s_data;
          sum_m_ready = 1'b1;
        end
        ST_RUN: begin
          sum_s_valid = s_valid && !full_s;
          s_ready     = sum_s_ready && !full_s;
          sum_s_data  = s_data;
          m_valid     = sum_m_valid;
          sum_m_ready = m_ready;
          primed      = 1'b1;
        end
        default: begin
          sum_m_ready = 1'b1;
        end
      endcase
    end else begin
      primed = 1'b0;
    end
  end

  // Next-state: in-flight tracking, zero-beat / discard counting and the clear override.
  always_comb begin
    in_hs_s  = sum_s_valid && sum_s_ready;
    out_hs_s = sum_m_valid && sum_m_ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (in_hs_s && !out_hs_s) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!in_hs_s && out_hs_s) begin
      inflight_d = inflight_q - INF_W'(1);
    end else begin
      inflight_d = inflight_q;
    end
    // clear wins over any transition; inflight keeps counting so stale sums drain in FLUSH
    if (clear) begin
      state_d = ST_FLUSH;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            if (inflight_q == INF_W'(0)) begin
              state_d = (LENGTH == 1) ? ST_RUN : ST_PRIME;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q;
            end
          end else if (in_hs_s) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_PRIME: begin
          if (out_hs_s) begin
            if (cnt_q == PRIME_LAST) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_FLUSH;
      cnt_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef WIPHY_MSUM_CTRL_STATS_EN
  logic [31:0] drop_count_q;
  logic [15:0] flush_count_q;
  logic        flush_done_s;

  assign flush_done_s = (state_q == ST_FLUSH) && (state_d != ST_FLUSH);

  // Saturating statistics; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_count_q  <= 32'd0;
      flush_count_q <= 16'd0;
    end else begin
      if (out_hs_s && (state_q != ST_RUN) && (drop_count_q != 32'hFFFF_FFFF)) begin
        drop_count_q <= drop_count_q + 32'd1;
      end else begin
        drop_count_q <= drop_count_q;
      end
      if (flush_done_s && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end else begin
        flush_count_q <= flush_count_q;
      end
    end
  end

  assign drop_count  = drop_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_moving_sum_window_ctrl.sv
// Directed bench: instance A (LENGTH=4, 1-cycle summer) and B (LENGTH=1, 6-cycle summer),
// each checked every cycle against a window-sum reference built from the accepted samples.
module tb_moving_sum_window_ctrl;
  localparam int W     = 16;
  localparam int LA    = 4;
  localparam int SWA   = W + 2;
  localparam int LB    = 1;
  localparam int SWB   = W;
  localparam int MAXI  = 4;
  localparam int LAT_A = 1;
  localparam int LAT_B = 6;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, got, exp);
    end
  endtask

  logic             clear_a, s_valid_a, s_ready_a, ss_valid_a, ss_ready_a;
  logic             sm_ready_a, m_valid_a, m_ready_a, primed_a;
  logic             sm_valid_a = 1'b0;
  logic [2*W-1:0]   s_data_a, ss_data_a;
  logic [2*SWA-1:0] sm_data_a = '0;
  logic [2*SWA-1:0] m_data_a;
  logic             clear_b, s_valid_b, s_ready_b, ss_valid_b, ss_ready_b;
  logic             sm_ready_b, m_valid_b, m_ready_b, primed_b;
  logic             sm_valid_b = 1'b0;
  logic [2*W-1:0]   s_data_b, ss_data_b;
  logic [2*SWB-1:0] sm_data_b = '0;
  logic [2*SWB-1:0] m_data_b;
`ifdef WIPHY_MSUM_CTRL_STATS_EN
  logic [31:0] drop_count_a, drop_count_b;
  logic [15:0] flush_count_a, flush_count_b;
`endif

  moving_sum_window_ctrl #(.WIDTH(W), .LENGTH(LA), .MAX_INFLIGHT(MAXI)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
    .sum_s_valid(ss_valid_a), .sum_s_ready(ss_ready_a), .sum_s_data(ss_data_a),
    .sum_m_valid(sm_valid_a), .sum_m_ready(sm_ready_a), .sum_m_data(sm_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
`ifdef WIPHY_MSUM_CTRL_STATS_EN
    .drop_count(drop_count_a), .flush_count(flush_count_a),
`endif
    .primed(primed_a));

  moving_sum_window_ctrl #(.WIDTH(W), .LENGTH(LB), .MAX_INFLIGHT(MAXI)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .sum_s_valid(ss_valid_b), .sum_s_ready(ss_ready_b), .sum_s_data(ss_data_b),
    .sum_m_valid(sm_valid_b), .sum_m_ready(sm_ready_b), .sum_m_data(sm_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
`ifdef WIPHY_MSUM_CTRL_STATS_EN
    .drop_count(drop_count_b), .flush_count(flush_count_b),
`endif
    .primed(primed_b));

  // handshake snapshots taken mid-cycle, consumed by the summer models after the edge
  logic           cap_rst = 1'b0;
  logic           cap_ss_hs_a = 1'b0, cap_sm_hs_a = 1'b0, cap_ss_hs_b = 1'b0, cap_sm_hs_b = 1'b0;
  logic [2*W-1:0] cap_ss_data_a, cap_ss_data_b;

  // summer models: window of accepted samples, results released after a fixed latency
  int               cyc = 0;
  int               sre, sim;
  logic [2*W-1:0]   win_a [LA];
  logic [2*SWA-1:0] rq_a [$];
  int               due_a [$];
  logic [2*SWB-1:0] rq_b [$];
  int               due_b [$];

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!cap_rst) begin
      rq_a.delete(); due_a.delete(); rq_b.delete(); due_b.delete();
      for (int k = 0; k < LA; k++) win_a[k] = '0;
    end else begin
      if (cap_sm_hs_a) begin void'(rq_a.pop_front()); void'(due_a.pop_front()); end
      if (cap_sm_hs_b) begin void'(rq_b.pop_front()); void'(due_b.pop_front()); end
      if (cap_ss_hs_a) begin
        for (int k = LA - 1; k > 0; k--) win_a[k] = win_a[k-1];
        win_a[0] = cap_ss_data_a;
        sre = 0; sim = 0;
        for (int k = 0; k < LA; k++) begin
          sre += int'($signed(win_a[k][W-1:0]));
          sim += int'($signed(win_a[k][2*W-1:W]));
        end
        rq_a.push_back({SWA'(sim), SWA'(sre)});
        due_a.push_back(cyc + LAT_A - 1);
      end
      if (cap_ss_hs_b) begin
        rq_b.push_back(cap_ss_data_b);
        due_b.push_back(cyc + LAT_B - 1);
      end
    end
    sm_valid_a = (rq_a.size() > 0) && (due_a[0] <= cyc);
    sm_data_a  = (rq_a.size() > 0) ? rq_a[0] : '0;
    sm_valid_b = (rq_b.size() > 0) && (due_b[0] <= cyc);
    sm_data_b  = (rq_b.size() > 0) ? rq_b[0] : '0;
  end

  // reference state for A: post-flush samples, output index, zero beats, in-flight count
  logic [2*W-1:0]   list_a [$];
  logic [2*SWA-1:0] got_a [$];
  logic [2*SWA-1:0] hold_data_a;
  int               out_a = 0, zb_a = 0, infl_a = 0, ere, eim;
  bit               flushed_a = 1'b0, hold_a = 1'b0;

  always @(negedge clk) begin
    cap_rst       = reset_n;
    cap_ss_hs_a   = ss_valid_a && ss_ready_a;
    cap_sm_hs_a   = sm_valid_a && sm_ready_a;
    cap_ss_data_a = ss_data_a;
    if (!reset_n) begin
      check("a_reset_quiet", {s_ready_a, ss_valid_a, sm_ready_a, m_valid_a, primed_a}, 64'd0);
      list_a.delete(); out_a = 0; zb_a = 0; infl_a = 0; flushed_a = 1'b0; hold_a = 1'b0;
    end else begin
      if (infl_a == MAXI) check("a_full_stall", {ss_valid_a, s_ready_a}, 64'd0);
      if (primed_a) check("a_run_pass", {m_valid_a, sm_ready_a, m_data_a}, {sm_valid_a, m_ready_a, sm_data_a});
      else          check("a_discard", {m_valid_a, sm_ready_a}, 64'd1);
      if (hold_a) check("a_hold", {m_valid_a, m_data_a}, {1'b1, hold_data_a});
      if (cap_ss_hs_a) begin
        if (!s_ready_a) begin
          check("a_zero_data", ss_data_a, 64'd0);
          check("a_zero_excess", zb_a < LA, 64'd1);
          zb_a++;
        end else begin
          check("a_pass_data", {s_valid_a, ss_data_a}, {1'b1, s_data_a});
        end
      end
      if (s_ready_a && !flushed_a) begin
        check("a_flush_beats", zb_a, LA);
        flushed_a = 1'b1;
      end
      if (m_valid_a && m_ready_a) begin
        if (out_a + LA <= list_a.size()) begin
          ere = 0; eim = 0;
          for (int k = out_a; k < out_a + LA; k++) begin
            ere += int'($signed(list_a[k][W-1:0]));
            eim += int'($signed(list_a[k][2*W-1:W]));
          end
          check("a_m_data", m_data_a, {SWA'(eim), SWA'(ere)});
        end else begin
          check("a_m_early", list_a.size(), out_a + LA);
        end
        got_a.push_back(m_data_a);
        out_a++;
      end
      if (s_valid_a && s_ready_a) list_a.push_back(s_data_a);
      infl_a += int'(cap_ss_hs_a) - int'(cap_sm_hs_a);
      hold_a      = m_valid_a && !m_ready_a && !clear_a;
      hold_data_a = m_data_a;
      if (clear_a) begin list_a.delete(); out_a = 0; zb_a = 0; flushed_a = 1'b0; end
    end
  end

  // reference state for B (LENGTH=1): every output equals the matching accepted sample
  logic [2*W-1:0]   list_b [$];
  logic [2*SWB-1:0] got_b [$];
  int               out_b = 0, zb_b = 0, infl_b = 0, max_infl_b = 0;
  bit               flushed_b = 1'b0, stall_seen_b = 1'b0;

  always @(negedge clk) begin
    cap_ss_hs_b   = ss_valid_b && ss_ready_b;
    cap_sm_hs_b   = sm_valid_b && sm_ready_b;
    cap_ss_data_b = ss_data_b;
    if (!reset_n) begin
      check("b_reset_quiet", {s_ready_b, ss_valid_b, sm_ready_b, m_valid_b, primed_b}, 64'd0);
      list_b.delete(); out_b = 0; zb_b = 0; infl_b = 0; flushed_b = 1'b0;
    end else begin
      if (infl_b == MAXI) begin
        check("b_full_stall", {ss_valid_b, s_ready_b}, 64'd0);
        if (s_valid_b) stall_seen_b = 1'b1;
      end
      if (primed_b) check("b_run_pass", {m_valid_b, sm_ready_b, m_data_b}, {sm_valid_b, m_ready_b, sm_data_b});
      else          check("b_discard", {m_valid_b, sm_ready_b}, 64'd1);
      if (cap_ss_hs_b) begin
        if (!s_ready_b) begin
          check("b_zero_data", ss_data_b, 64'd0);
          zb_b++;
        end else begin
          check("b_pass_data", {s_valid_b, ss_data_b}, {1'b1, s_data_b});
        end
      end
      if (s_ready_b && !flushed_b) begin
        check("b_flush_beats", zb_b, LB);
        flushed_b = 1'b1;
      end
      if (m_valid_b && m_ready_b) begin
        if (out_b < list_b.size()) check("b_m_data", m_data_b, list_b[out_b]);
        else                       check("b_m_early", list_b.size(), out_b + 1);
        got_b.push_back(m_data_b);
        out_b++;
      end
      if (s_valid_b && s_ready_b) list_b.push_back(s_data_b);
      infl_b += int'(cap_ss_hs_b) - int'(cap_sm_hs_b);
      if (infl_b > max_infl_b) max_infl_b = infl_b;
    end
  end

  task automatic send(input bit to_b, input logic [15:0] re, input logic [15:0] im);
    int n;
    if (to_b) begin s_valid_b = 1'b1; s_data_b = {im, re}; end
    else      begin s_valid_a = 1'b1; s_data_a = {im, re}; end
    n = 0;
    @(negedge clk);
    while (!(to_b ? s_ready_b : s_ready_a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(to_b ? "b_send_timeout" : "a_send_timeout", to_b ? s_ready_b : s_ready_a, 64'd1);
    @(posedge clk);
    #1;
    if (to_b) s_valid_b = 1'b0;
    else      s_valid_a = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    clear_a = 1'b0; s_valid_a = 1'b0; s_data_a = '0; ss_ready_a = 1'b1; m_ready_a = 1'b1;
    clear_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0; ss_ready_b = 1'b1; m_ready_b = 1'b1;
    cycles(3);
    reset_n = 1'b1;

    // 1: four zero beats, no input accepted, then PRIME
    cycles(12);
    check("t1_zero_beats", zb_a, 64'd4);
    check("t1_prime_ready", s_ready_a, 64'd1);
    check("t1_not_primed", primed_a, 64'd0);

    // 2: ramp 1..8 -> first three sums discarded
    for (int i = 1; i <= 8; i++) send(1'b0, 16'(i), 16'd0);
    cycles(6);
    check("t2_out_count", got_a.size(), 64'd5);
    for (int i = 0; i < 5; i++) check("t2_out_value", (i < got_a.size()) ? got_a[i] : '0, 64'(10 + 4 * i));
    check("t2_primed", primed_a, 64'd1);

    // 3: backpressure long enough to fill the in-flight budget
    fork
      begin
        for (int v = 9; v <= 14; v++) send(1'b0, 16'(v), 16'd0);
      end
      begin
        m_ready_a = 1'b0;
        cycles(7);
        check("t3_s_stalled", s_ready_a, 64'd0);
        check("t3_sum_m_ready", sm_ready_a, 64'd0);
        check("t3_held", {m_valid_a, m_data_a}, {1'b1, 36'd30});
        m_ready_a = 1'b1;
      end
    join
    cycles(8);
    check("t3_out_count", got_a.size(), 64'd11);
    check("t3_first_after", (got_a.size() > 5) ? got_a[5] : '0, 64'd30);
    check("t3_last", (got_a.size() > 10) ? got_a[10] : '0, 64'd50);

    // 4: clear with two sums in flight
    m_ready_a = 1'b0;
    send(1'b0, 16'd15, 16'd0);
    send(1'b0, 16'd16, 16'd0);
    cycles(2);
    check("t4_pending", m_valid_a, 64'd1);
    clear_a = 1'b1;
    cycles(1);
    clear_a = 1'b0;
    check("t4_unprimed", primed_a, 64'd0);
    m_ready_a = 1'b1;
    cycles(12);
    check("t4_dropped", got_a.size(), 64'd11);
    check("t4_reprime", {primed_a, s_ready_a}, 64'd1);
    send(1'b0, 16'd100, 16'd1);
    send(1'b0, 16'd200, 16'd2);
    send(1'b0, 16'd300, 16'd3);
    send(1'b0, 16'd400, 16'd4);
    cycles(4);
    check("t4_out_count", got_a.size(), 64'd12);
    check("t4_first", (got_a.size() > 11) ? got_a[11] : '0, {28'd0, 18'd10, 18'd1000});

    // 5: reset in the middle of a flush
    clear_a = 1'b1;
    cycles(1);
    clear_a = 1'b0;
    n = 0;
    while (zb_a < 2 && n < 30) begin cycles(1); n++; end
    check("t5_mid_flush", zb_a >= 2, 64'd1);
    reset_n = 1'b0;
    cycles(3);
    check("t5_quiet", {ss_valid_a, ss_valid_b, primed_b}, 64'd0);
    reset_n = 1'b1;
    cycles(12);
    check("t5_fresh_zeros", zb_a, 64'd4);
    check("t5_prime", {primed_a, s_ready_a}, 64'd1);

    // 6: LENGTH=1 with a slow summer
    check("t6_run", {primed_b, 31'(zb_b)}, {1'b1, 31'd1});
    for (int i = 0; i < 8; i++) send(1'b1, 16'(3 * i + 1), 16'(i));
    cycles(20);
    check("t6_out_count", got_b.size(), 64'd8);
    check("t6_stall_seen", stall_seen_b, 64'd1);
    check("t6_max_inflight", max_infl_b, 64'd4);
    check("t6_first", (got_b.size() > 0) ? got_b[0] : '0, {32'd0, 16'd0, 16'd1});
    check("t6_last", (got_b.size() > 7) ? got_b[7] : '0, {32'd0, 16'd7, 16'd22});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
